// File: rtl/display_scheduler.sv
// Round-robin time-sharing of the four-digit display between three requesters,
// holding each granted 16-bit value for HOLD_CYCLES clocks; all outputs registered.
module display_scheduler #(
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [15:0] val0,
  input  logic [15:0] val1,
  input  logic [15:0] val2,
  output logic [2:0]  ack,
  output logic [1:0]  owner,
  output logic        busy,
  output logic [3:0]  d0,
  output logic [3:0]  d1,
  output logic [3:0]  d2,
  output logic [3:0]  d3
);

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD_CYCLES - 1);

  typedef enum logic {IDLE, SHOW} state_t;

  state_t      state_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]  last_q;
  logic [2:0]  ack_q;
  logic [1:0]  owner_q;
  logic        busy_q;
  logic [15:0] disp_q;

  logic        win_vld_d;
  logic [1:0]  win_idx_d;
  logic [1:0]  scan_idx;
  logic [15:0] win_val_d;
  logic        arb_d;

  // Scan last+1, last+2, last+3 (mod 3); first requester found wins.
  always_comb begin
    win_vld_d = 1'b0;
    win_idx_d = 2'd0;
    scan_idx  = last_q;
    for (int k = 0; k < 3; k++) begin
      scan_idx = (scan_idx == 2'd2) ? 2'd0 : scan_idx + 2'd1;
      if (!win_vld_d && req[scan_idx]) begin
        win_vld_d = 1'b1;
        win_idx_d = scan_idx;
      end
    end
  end

  always_comb begin
    case (win_idx_d)
      2'd0:    win_val_d = val0;
      2'd1:    win_val_d = val1;
      default: win_val_d = val2;
    endcase
  end

  assign arb_d = ((state_q == IDLE) || (cnt_q == '0)) && win_vld_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 2'd2;
      ack_q   <= 3'b000;
      owner_q <= 2'd3;
      busy_q  <= 1'b0;
      disp_q  <= 16'h0000;
    end else begin
      ack_q <= 3'b000;
      if (arb_d) begin
        state_q <= SHOW;
        cnt_q   <= CNT_LOAD;
        last_q  <= win_idx_d;
        owner_q <= win_idx_d;
        ack_q   <= 3'b001 << win_idx_d;
        busy_q  <= 1'b1;
        disp_q  <= win_val_d;
      end else if (state_q == SHOW) begin
        if (cnt_q != '0) begin
          cnt_q <= cnt_q - 1'b1;
        end else begin
          // Expired with nobody asking: stop the dwell but leave the digits up.
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      end
    end
  end

  assign ack   = ack_q;
  assign owner = owner_q;
  assign busy  = busy_q;
  assign d0    = disp_q[3:0];
  assign d1    = disp_q[7:4];
  assign d2    = disp_q[11:8];
  assign d3    = disp_q[15:12];

endmodule

// File: tb/tb_display_scheduler.sv
// Bench for display_scheduler with HOLD_CYCLES = 4: vector table, corner sequences,
// and random traffic against a time-stamp based reference model.
module tb_display_scheduler;

  localparam int H = 4;

  logic        clk;
  logic        rst;
  logic [2:0]  req;
  logic [15:0] val0, val1, val2;
  logic [2:0]  ack;
  logic [1:0]  owner;
  logic        busy;
  logic [3:0]  d0, d1, d2, d3;

  int n_tests = 0;
  int n_fail  = 0;

  display_scheduler #(.HOLD_CYCLES(H)) dut (
    .clk(clk), .rst(rst), .req(req),
    .val0(val0), .val1(val1), .val2(val2),
    .ack(ack), .owner(owner), .busy(busy),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  req;
    logic [15:0] v0, v1, v2;
    logic [2:0]  ack;
    logic [1:0]  owner;
    logic        busy;
    logic [15:0] disp;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mk(logic [2:0] r, logic [15:0] a, logic [15:0] b, logic [15:0] c,
                              logic [2:0] k, logic [1:0] o, logic bz, logic [15:0] dd);
    vec_t v;
    v.req = r; v.v0 = a; v.v1 = b; v.v2 = c;
    v.ack = k; v.owner = o; v.busy = bz; v.disp = dd;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(string tag, logic [2:0] e_ack, logic [1:0] e_own, logic e_busy,
                         logic [15:0] e_disp);
    chk({tag, ".ack"},   32'(ack),   32'(e_ack));
    chk({tag, ".owner"}, 32'(owner), 32'(e_own));
    chk({tag, ".busy"},  32'(busy),  32'(e_busy));
    chk({tag, ".disp"},  32'({d3, d2, d1, d0}), 32'(e_disp));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Asserted mid-cycle; outputs are checked before any clock edge arrives.
  task automatic do_reset(string tag);
    #2 rst = 1'b1;
    #1 chk_out(tag, 3'b000, 2'd3, 1'b0, 16'h0000);
    req = 3'b000;
    step();
    rst = 1'b0;
  endtask

  // Reference model: grant allowed when idle or H cycles have passed since the last grant.
  int          m_cyc, m_gcyc, m_last;
  bit          m_show;
  logic [2:0]  m_ack;
  logic [1:0]  m_owner;
  logic        m_busy;
  logic [15:0] m_disp;

  task automatic model_reset();
    m_cyc = 0; m_gcyc = 0; m_last = 2; m_show = 0;
    m_ack = 3'b000; m_owner = 2'd3; m_busy = 1'b0; m_disp = 16'h0000;
  endtask

  task automatic model_step();
    logic [15:0] vals[3];
    bit granted;
    vals[0] = val0; vals[1] = val1; vals[2] = val2;
    m_cyc++;
    m_ack = 3'b000;
    if (!m_show || (m_cyc - m_gcyc) >= H) begin
      granted = 0;
      for (int k = 1; k <= 3; k++) begin
        int i;
        i = (m_last + k) % 3;
        if (!granted && req[i]) begin
          granted = 1;
          m_last = i; m_owner = 2'(i); m_ack = 3'(1 << i);
          m_disp = vals[i]; m_gcyc = m_cyc; m_show = 1;
        end
      end
      if (!granted) m_show = 0;
    end
    m_busy = m_show;
  endtask

  initial begin
    rst = 1'b0; req = 3'b000; val0 = 16'h0; val1 = 16'h0; val2 = 16'h0;

    // Single request, expiry, then full contention rotating from last = 0.
    tbl[0]  = mk(3'b001, 16'hBEEF, 16'h0000, 16'h0000, 3'b001, 2'd0, 1'b1, 16'hBEEF);
    tbl[1]  = mk(3'b000, 16'h0000, 16'h0000, 16'h0000, 3'b000, 2'd0, 1'b1, 16'hBEEF);
    tbl[2]  = mk(3'b000, 16'h0000, 16'h0000, 16'h0000, 3'b000, 2'd0, 1'b1, 16'hBEEF);
    tbl[3]  = mk(3'b000, 16'h0000, 16'h0000, 16'h0000, 3'b000, 2'd0, 1'b1, 16'hBEEF);
    tbl[4]  = mk(3'b000, 16'h0000, 16'h0000, 16'h0000, 3'b000, 2'd0, 1'b0, 16'hBEEF);
    tbl[5]  = mk(3'b000, 16'h0000, 16'h0000, 16'h0000, 3'b000, 2'd0, 1'b0, 16'hBEEF);
    tbl[6]  = mk(3'b111, 16'h1111, 16'h2222, 16'h3333, 3'b010, 2'd1, 1'b1, 16'h2222);
    tbl[7]  = mk(3'b111, 16'h1111, 16'h2222, 16'h3333, 3'b000, 2'd1, 1'b1, 16'h2222);
    tbl[8]  = mk(3'b111, 16'h1111, 16'h2222, 16'h3333, 3'b000, 2'd1, 1'b1, 16'h2222);
    tbl[9]  = mk(3'b111, 16'h1111, 16'h2222, 16'h3333, 3'b000, 2'd1, 1'b1, 16'h2222);
    tbl[10] = mk(3'b111, 16'h1111, 16'h2222, 16'h3333, 3'b100, 2'd2, 1'b1, 16'h3333);
    tbl[11] = mk(3'b111, 16'h1111, 16'h2222, 16'h3333, 3'b000, 2'd2, 1'b1, 16'h3333);
    tbl[12] = mk(3'b111, 16'h1111, 16'h2222, 16'h3333, 3'b000, 2'd2, 1'b1, 16'h3333);
    tbl[13] = mk(3'b111, 16'h1111, 16'h2222, 16'h3333, 3'b000, 2'd2, 1'b1, 16'h3333);
    tbl[14] = mk(3'b111, 16'h1111, 16'h2222, 16'h3333, 3'b001, 2'd0, 1'b1, 16'h1111);
    tbl[15] = mk(3'b111, 16'h1111, 16'h2222, 16'h3333, 3'b000, 2'd0, 1'b1, 16'h1111);
    tbl[16] = mk(3'b111, 16'h1111, 16'h2222, 16'h3333, 3'b000, 2'd0, 1'b1, 16'h1111);
    tbl[17] = mk(3'b111, 16'h1111, 16'h2222, 16'h3333, 3'b000, 2'd0, 1'b1, 16'h1111);
    tbl[18] = mk(3'b111, 16'h1111, 16'h2222, 16'h3333, 3'b010, 2'd1, 1'b1, 16'h2222);

    #1;
    do_reset("reset");
    for (int i = 0; i < 19; i++) begin
      req = tbl[i].req; val0 = tbl[i].v0; val1 = tbl[i].v1; val2 = tbl[i].v2;
      step();
      chk_out($sformatf("vec%0d", i), tbl[i].ack, tbl[i].owner, tbl[i].busy, tbl[i].disp);
    end
    req = 3'b000;

    // Value changed during the dwell is ignored until the re-grant.
    do_reset("reset_b");
    req = 3'b010; val1 = 16'h00A5;
    step();
    chk_out("midval_grant", 3'b010, 2'd1, 1'b1, 16'h00A5);
    val1 = 16'hFFFF;
    for (int i = 0; i < H - 1; i++) begin
      step();
      chk_out($sformatf("midval_hold%0d", i), 3'b000, 2'd1, 1'b1, 16'h00A5);
    end
    step();
    chk_out("midval_regrant", 3'b010, 2'd1, 1'b1, 16'hFFFF);
    req = 3'b000;

    // Late requester: granted exactly at expiry, busy never drops.
    do_reset("reset_c");
    req = 3'b001; val0 = 16'h1234; val2 = 16'hABCD;
    step();
    chk_out("late_grant0", 3'b001, 2'd0, 1'b1, 16'h1234);
    req = 3'b100;
    for (int i = 0; i < H - 1; i++) begin
      step();
      chk_out($sformatf("late_wait%0d", i), 3'b000, 2'd0, 1'b1, 16'h1234);
    end
    step();
    chk_out("late_grant2", 3'b100, 2'd2, 1'b1, 16'hABCD);
    req = 3'b000;

    // Reset mid-dwell aborts it and restarts the search at requester 0.
    do_reset("reset_d");
    req = 3'b100; val2 = 16'h5555;
    step();
    chk_out("rstmid_grant", 3'b100, 2'd2, 1'b1, 16'h5555);
    req = 3'b000;
    step();
    step();
    do_reset("rstmid_reset");
    req = 3'b110; val1 = 16'h7777;
    step();
    chk_out("rstmid_after", 3'b010, 2'd1, 1'b1, 16'h7777);
    req = 3'b000;

    // Random traffic against the model.
    do_reset("reset_r");
    model_reset();
    for (int c = 0; c < 1500; c++) begin
      req  = ($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
      val0 = 16'($urandom); val1 = 16'($urandom); val2 = 16'($urandom);
      @(posedge clk);
      model_step();
      #1;
      chk_out($sformatf("rnd%0d", c), m_ack, m_owner, m_busy, m_disp);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/display_scheduler.md
# display_scheduler

Time-shares the four-digit seven-segment display between three requesters: ALU result, operand view and status/error code. It arbitrates round-robin and holds each granted 16-bit value on the display for a fixed dwell time. Its d0..d3 outputs feed the display driver's digit inputs directly. Requesters use a level request with a single-cycle acknowledge.

## Interface
- HOLD_CYCLES, default 50_000_000: dwell time in clk cycles per grant (0.5 s at 100 MHz); legal range ≥ 1.
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  reset rst, asynchronous, active-high.
- req  input  3  level request per requester; bit i belongs to vali.
- val0  input  16  value of requester 0 (ALU result).
- val1  input  16  value of requester 1 (operands).
- val2  input  16  value of requester 2 (status code).
- ack  output  3  one-hot, one-cycle pulse on the cycle a grant takes effect.
- owner  output  2  index of the requester currently displayed; 2'd3 = none since reset.
- busy  output  1  high while a dwell period is running.
- d0  output  4  digit 0 nibble, val[3:0] of the granted value.
- d1  output  4  digit 1 nibble, val[7:4].
- d2  output  4  digit 2 nibble, val[11:8].
- d3  output  4  digit 3 nibble, val[15:12].

## Operation
- States:
  - IDLE: no dwell running.
  - SHOW: dwell counter running.
- Reset values:
  - State: IDLE.
  - Outputs: d0..d3 = 0, ack = 0, owner = 3, busy = 0.
  - Round-robin pointer last = 2, so the first search starts at requester 0.
- Arbitration event occurs when (state = IDLE or dwell counter = 0) and req ≠ 0.
  - Search order is last+1, last+2, last+3, all mod 3.
  - The first set req bit wins index w.
- On an arbitration event, at the same edge:
  - Latch valw into d3..d0.
  - Set owner = w and last = w.
  - Pulse ack[w].
  - Load counter = HOLD_CYCLES-1.
  - Enter or stay in SHOW, with busy = 1.
- In SHOW with counter > 0: decrement the counter by 1; outputs are unchanged.
- In SHOW with counter = 0 and req = 0: go to IDLE with busy = 0.
  - d0..d3 and owner keep the last value, so the display is sticky and never blanked.
- Values are sampled only at the grant edge. Changes to valw during the dwell are ignored.
- req is level-sensitive. A requester that keeps req high after ack stays eligible, but yields to the others through round-robin.
- A single persistent requester is re-granted every HOLD_CYCLES cycles, with an ack pulse each time and its value re-sampled each time.
- Counter width is $clog2(HOLD_CYCLES) bits, minimum 1.
- Counter arithmetic is unsigned and never wraps below 0.
- No combinational path from req or val to any output; all outputs are registered.

## Timing
- Grant latency: req sampled at edge k produces ack, owner and d updated after edge k (visible in cycle k+1).
- ack is high for exactly one cycle per grant and is never asserted for more than one bit.
- Dwell: after a grant, d0..d3 stay stable for exactly HOLD_CYCLES cycles before the next grant may change them.
- Back-to-back grants have no idle gap: the expiry cycle with req ≠ 0 grants on the same edge.
- With HOLD_CYCLES = 1, grants occur every cycle under contention.
- A request arriving mid-dwell waits until expiry. A request withdrawn before expiry is never granted.
- Asynchronous rst mid-dwell immediately forces all reset values and aborts the dwell. The first grant after release starts at requester 0.

## Test plan
All scenarios use HOLD_CYCLES = 4.
- Reset check: assert rst asynchronously mid-cycle, with no clock edge needed.
  - Required: d0..d3 = 0, owner = 3, busy = 0, ack = 0.
- Single request: req = 3'b001 for 1 cycle with val0 = 16'hBEEF.
  - Next cycle: ack = 001 and d3..d0 = B,E,E,F.
  - busy drops 4 cycles after the grant.
  - Digits stay BEEF afterwards.
- Full contention: req = 3'b111 held, with val0 = 16'h1111, val1 = 16'h2222, val2 = 16'h3333.
  - Grants rotate 0,1,2,0 at 4-cycle intervals.
  - ack is one-hot per grant, and d0..d3 never change between grants.
- Value change mid-dwell: grant val1 = 16'h00A5, then change val1 to 16'hFFFF.
  - Display stays 00A5 until expiry.
  - If req[1] is still high, the re-grant shows FFFF.
- Late requester: after req[0] is granted, assert req[2] at dwell cycle 1.
  - Grant to 2 happens exactly at expiry, with no idle cycle and busy staying 1.
- Reset mid-dwell: assert rst during dwell cycle 2, release it, then assert req = 3'b110.
  - Required: the first post-reset grant goes to 1, owner = 1.
